// File: rtl/button_cond_pkg.sv
// button_cond_pkg: FSM state encodings and 24 MHz timing defaults
// shared by the push-button workshop blocks.
package button_cond_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_DEB_PRESS = 2'd1;
   localparam logic [1:0] ST_HELD      = 2'd2;
   localparam logic [1:0] ST_DEB_REL   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE      = ST_IDLE,
      S_DEB_PRESS = ST_DEB_PRESS,
      S_HELD      = ST_HELD,
      S_DEB_REL   = ST_DEB_REL
   } btn_state_t;

   localparam int unsigned CLK_HZ = 24_000_000;
   // 10 ms debounce window and 1 s long-press hold
   localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
   localparam int unsigned DEF_LONG_CYCLES     = CLK_HZ;

endpackage

// File: rtl/button_cond_if.sv
// button_cond_if: bundle of the raw pin and the conditioned events.
// master = conditioner side (drives level/press/rls/lng), slave = consumer.
interface button_cond_if;

   logic btn;
   logic level;
   logic press;
   logic rls;
   logic lng;

   modport master (
      input  btn,
      output level, press, rls, lng
   );

   modport slave (
      output btn,
      input  level, press, rls, lng
   );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous input pin.
// Ports: i_clk, i_rst_n (async low), i_d (async in), o_q (synchronised).
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/button_cond.sv
// button_cond: debounced push-button with press/release/long-press pulses.
// Ports: i_clk, i_rst_n (async low), i_btn (raw pin), o_level (debounced),
// o_press/o_release/o_long (one-cycle pulses).
// Option: define BUTTON_COND_LONG_PRESS_EN to build the long-press counter.
module button_cond
   import button_cond_pkg::*;
#(
   parameter int unsigned P_DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned P_LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter bit          P_ACTIVE_LOW      = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long
);

   if (P_DEBOUNCE_CYCLES < 1 || P_LONG_CYCLES < 1) begin : g_cfg_err
      $error("button_cond: cycle parameters must be >= 1");
   end

   localparam int DW = $clog2(P_DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(P_DEBOUNCE_CYCLES - 1);

   logic       w_raw;
   logic       w_s_btn;
   logic       w_rel_side;
   logic       w_new_lvl;
   logic       w_acc;

   btn_state_t    r_state;
   logic [DW-1:0] r_deb_cnt;
   logic          r_level;
   logic          r_press;
   logic          r_release;

   assign w_raw = P_ACTIVE_LOW ? ~i_btn : i_btn;

   sync_2ff u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (w_raw),
      .o_q     (w_s_btn)
   );

   // The cycle that first sees the new level in IDLE/HELD counts as
   // sample one, so r_deb_cnt holds samples already seen and the
   // P-th consecutive sample is accepted when it equals P-1.
   assign w_rel_side = (r_state == S_HELD) || (r_state == S_DEB_REL);
   assign w_new_lvl  = w_s_btn ^ w_rel_side;
   assign w_acc      = w_new_lvl && (r_deb_cnt == DEB_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_deb_cnt <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DEB_PRESS: begin
               if (!w_s_btn) begin
                  r_state   <= S_IDLE;
                  r_deb_cnt <= '0;
               end else if (w_acc) begin
                  r_state   <= S_HELD;
                  r_deb_cnt <= '0;
                  r_level   <= 1'b1;
                  r_press   <= 1'b1;
               end else begin
                  r_state   <= S_DEB_PRESS;
                  r_deb_cnt <= r_deb_cnt + DW'(1);
               end
            end
            S_HELD, S_DEB_REL: begin
               if (w_s_btn) begin
                  r_state   <= S_HELD;
                  r_deb_cnt <= '0;
               end else if (w_acc) begin
                  r_state   <= S_IDLE;
                  r_deb_cnt <= '0;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
               end else begin
                  r_state   <= S_DEB_REL;
                  r_deb_cnt <= r_deb_cnt + DW'(1);
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_deb_cnt <= '0;
            end
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

`ifdef BUTTON_COND_LONG_PRESS_EN
   localparam int LW = $clog2(P_LONG_CYCLES + 1);
   localparam logic [LW-1:0] LONG_LAST = LW'(P_LONG_CYCLES - 1);
   localparam logic [LW-1:0] LONG_MAX  = LW'(P_LONG_CYCLES);

   logic [LW-1:0] r_long_cnt;
   logic          r_long;

   // Counts while pressed (glitches included), saturates at P so the
   // pulse fires once; an accepted release clears it before it fires.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_long_cnt <= '0;
         r_long     <= 1'b0;
      end else begin
         r_long <= 1'b0;
         if (!w_rel_side || w_acc) begin
            r_long_cnt <= '0;
         end else if (r_long_cnt != LONG_MAX) begin
            r_long_cnt <= r_long_cnt + LW'(1);
            r_long     <= (r_long_cnt == LONG_LAST);
         end
      end
   end

   assign o_long = r_long;
`else
   assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_cond.sv
// tb_button_cond: run-length reference model plus directed latency checks
// and randomized bouncing/reset stimulus for button_cond.
module tb_button_cond;

   localparam int P_DEB = 4;
   localparam int P_LNG = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   button_cond_if bif ();

   always #5 clk = ~clk;

   button_cond #(
      .P_DEBOUNCE_CYCLES (P_DEB),
      .P_LONG_CYCLES     (P_LNG),
      .P_ACTIVE_LOW      (1'b0)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_btn     (bif.btn),
      .o_level   (bif.level),
      .o_press   (bif.press),
      .o_release (bif.rls),
      .o_long    (bif.lng)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d",
                  name, cyc, act, exp);
      end
   endtask

   // Reference model: level flips after P_DEB consecutive synchronised
   // samples disagreeing with it; synchronised sample = raw two edges ago.
   logic m_level;
   int   m_run;
   int   m_held;
   logic e_press, e_rel, e_long;
   logic raw_q[$];
   logic s;

   initial begin
      m_level = 1'b0;
      m_run   = 0;
      m_held  = 0;
      forever begin
         @(posedge clk);
         cyc++;
         e_press = 1'b0;
         e_rel   = 1'b0;
         e_long  = 1'b0;
         if (!rst_n) begin
            raw_q.delete();
            m_level = 1'b0;
            m_run   = 0;
            m_held  = 0;
         end else begin
            s = (raw_q.size() >= 2) ? raw_q[0] : 1'b0;
            raw_q.push_back(bif.btn);
            if (raw_q.size() > 2) void'(raw_q.pop_front());
            if (s != m_level) m_run++;
            else m_run = 0;
            if (m_run == P_DEB) begin
               m_run   = 0;
               m_level = s;
               if (s) begin
                  e_press = 1'b1;
                  m_held  = 0;
               end else begin
                  e_rel = 1'b1;
               end
            end else if (m_level) begin
               m_held++;
`ifdef BUTTON_COND_LONG_PRESS_EN
               if (m_held == P_LNG) e_long = 1'b1;
`endif
            end
         end
         #2;
         chk("level", int'(bif.level), int'(m_level));
         chk("press", int'(bif.press), int'(e_press));
         chk("release", int'(bif.rls), int'(e_rel));
         chk("long", int'(bif.lng), int'(e_long));
      end
   end

   function automatic bit hit(input int sel);
      if (sel == 0) return bif.press;
      if (sel == 1) return bif.rls;
      return bif.lng;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns the edge offset from c0 of the first pulse, or -1.
   task automatic wait_evt(input int sel, input int c0,
                           input int budget, output int off);
      off = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #2;
         if (hit(sel)) begin
            off = cyc - c0;
            break;
         end
      end
   endtask

   task automatic count_evt(input int sel, input int c0, input int n,
                            output int cnt, output int first);
      cnt   = 0;
      first = -1;
      repeat (n) begin
         @(posedge clk);
         #2;
         if (hit(sel)) begin
            if (first < 0) first = cyc - c0;
            cnt++;
         end
      end
   endtask

   int c0, off, p, n, f, nl;

   initial begin
      bif.btn = 1'b0;
      tick(3);
      #1;
      chk("rst_level", int'(bif.level), 0);
      chk("rst_press", int'(bif.press), 0);
      chk("rst_rel", int'(bif.rls), 0);
      chk("rst_long", int'(bif.lng), 0);
      rst_n = 1'b1;
      tick(4);

      // clean press, long hold, release
      bif.btn = 1'b1;
      c0 = cyc;
      wait_evt(0, c0, 20, off);
      chk("press_lat", off, 6);
      chk("press_level", int'(bif.level), 1);
      p = cyc;
      count_evt(2, p, 30, n, f);
`ifdef BUTTON_COND_LONG_PRESS_EN
      chk("long_count", n, 1);
      chk("long_at", f, 20);
`else
      chk("long_count", n, 0);
`endif
      tick(1);
      bif.btn = 1'b0;
      c0 = cyc;
      wait_evt(1, c0, 20, off);
      chk("rel_lat", off, 6);
      chk("rel_level", int'(bif.level), 0);

      // bounce rejected
      tick(5);
      bif.btn = 1'b1;
      tick(3);
      bif.btn = 1'b0;
      count_evt(0, cyc, 15, n, f);
      chk("bounce_press", n, 0);
      chk("bounce_level", int'(bif.level), 0);

      // short press
      tick(1);
      bif.btn = 1'b1;
      c0 = cyc;
      wait_evt(0, c0, 20, off);
      chk("short_press_lat", off, 6);
      count_evt(2, cyc, 10, nl, f);
      tick(1);
      bif.btn = 1'b0;
      c0 = cyc;
      wait_evt(1, c0, 20, off);
      chk("short_rel_lat", off, 6);
      count_evt(2, cyc, 20, n, f);
      chk("short_no_long", n + nl, 0);

      // reset at debounce count 2, button held through reset
      tick(5);
      bif.btn = 1'b1;
      tick(4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_level", int'(bif.level), 0);
      chk("mid_rst_press", int'(bif.press), 0);
      tick(2);
      rst_n = 1'b1;
      c0 = cyc;
      wait_evt(0, c0, 20, off);
      chk("post_rst_press_lat", off, 6);

      // reset while held clears the level at once
      tick(3);
      rst_n = 1'b0;
      #1;
      chk("held_rst_level", int'(bif.level), 0);
      tick(2);
      rst_n = 1'b1;
      c0 = cyc;
      wait_evt(0, c0, 20, off);
      chk("held_rst_press_lat", off, 6);
      tick(1);
      bif.btn = 1'b0;
      c0 = cyc;
      wait_evt(1, c0, 20, off);
      chk("held_rst_rel_lat", off, 6);

      // random bouncing with occasional resets
      for (int i = 0; i < 80; i++) begin
         tick($urandom_range(1, 40));
         if ($urandom_range(0, 14) == 0) begin
            rst_n = 1'b0;
            tick(2);
            rst_n = 1'b1;
         end
         bif.btn = ~bif.btn;
      end
      tick(10);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
